render_scheduler: RTL and testbench

RENDER_SCHEDULER -- requirements
Module: render_scheduler

---
 rtl/render_scheduler_if.sv | 58 +++++
 rtl/render_scheduler.sv | 163 ++++++++++++++++
 tb/tb_render_scheduler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/render_scheduler_if.sv
// Streams and side signals between the render scheduler and its pixel pipeline.
//
// Handshake rule used by all three AXI-Stream style channels: a beat transfers
// on a rising clock edge where tvalid and tready are both 1. A source that has
// raised tvalid keeps tvalid and tdata stable until that transfer happens, and
// tvalid never depends combinationally on tready. The hcount and vcount
// channels are issued as a pair: their tvalids are identical, and a
// coordinate moves only when both treadys are 1.
interface render_scheduler_if #(
    parameter int ADDR_W = 20
);
    logic              start;
    logic              busy;
    logic              frame_done;
    logic [10:0]       hcount_axis_tdata;
    logic              hcount_axis_tvalid;
    logic              hcount_axis_tready;
    logic [9:0]        vcount_axis_tdata;
    logic              vcount_axis_tvalid;
    logic              vcount_axis_tready;
    logic [23:0]       pixel_axis_tdata;
    logic              pixel_axis_tvalid;
    logic              pixel_axis_tready;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [23:0]       fb_wdata;
    logic              err_order;

    // Scheduler side
    modport master (
        input  start,
        output busy, frame_done,
        output hcount_axis_tdata, hcount_axis_tvalid,
        input  hcount_axis_tready,
        output vcount_axis_tdata, vcount_axis_tvalid,
        input  vcount_axis_tready,
        input  pixel_axis_tdata, pixel_axis_tvalid,
        output pixel_axis_tready,
        input  hcount_in, vcount_in,
        output fb_we, fb_addr, fb_wdata, err_order
    );

    // Pipeline / controller side
    modport slave (
        output start,
        input  busy, frame_done,
        input  hcount_axis_tdata, hcount_axis_tvalid,
        output hcount_axis_tready,
        input  vcount_axis_tdata, vcount_axis_tvalid,
        output vcount_axis_tready,
        output pixel_axis_tdata, pixel_axis_tvalid,
        input  pixel_axis_tready,
        output hcount_in, vcount_in,
        input  fb_we, fb_addr, fb_wdata, err_order
    );
endinterface

// File: rtl/render_scheduler.sv
// Render scheduler: issues raster coordinates to a pixel pipeline with a cap on
// coordinates in flight, writes returned pixels into the framebuffer and flags
// pixels that come back out of raster order.
module render_scheduler #(
    parameter int H_ACTIVE        = 1280,
    parameter int V_ACTIVE        = 720,
    parameter int MAX_OUTSTANDING = 512,
    parameter int ADDR_W          = 20
) (
    input  logic               aclk,
    input  logic               areset,
    render_scheduler_if.master bus,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PROD_W = (ADDR_W > 32) ? ADDR_W : 32;

    state_t            state_q, state_d;
    logic [10:0]       h_q, h_d, eh_q, eh_d;
    logic [9:0]        v_q, v_d, ev_q, ev_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic              err_q, err_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [23:0]       fb_wdata_q, fb_wdata_d;

    logic              coord_valid, accept, pixel_ready, pix_hs;
    logic              h_last, v_last, eh_last, ev_last;
    logic [PROD_W-1:0] addr_full;

    // Handshake qualifiers and raster-position decodes
    always_comb begin
        coord_valid = (state_q == ISSUE) && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
        accept      = coord_valid && bus.hcount_axis_tready && bus.vcount_axis_tready;
        pixel_ready = (state_q == ISSUE) || (state_q == DRAIN);
        pix_hs      = bus.pixel_axis_tvalid && pixel_ready;
        h_last      = (h_q  == 11'(H_ACTIVE - 1));
        v_last      = (v_q  == 10'(V_ACTIVE - 1));
        eh_last     = (eh_q == 11'(H_ACTIVE - 1));
        ev_last     = (ev_q == 10'(V_ACTIVE - 1));
        addr_full   = PROD_W'(bus.vcount_in) * PROD_W'(H_ACTIVE) + PROD_W'(bus.hcount_in);
    end

    // Next-state, counters and framebuffer write staging
    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        eh_d          = eh_q;
        ev_d          = ev_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;
        fb_we_d       = pix_hs;
        fb_addr_d     = fb_addr_q;
        fb_wdata_d    = fb_wdata_q;

        // Issue raster: the final beat wraps both counters back to the origin
        if (accept) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end

        // Return raster, order check and write capture
        if (pix_hs) begin
            fb_addr_d  = addr_full[ADDR_W-1:0];
            fb_wdata_d = bus.pixel_axis_tdata;
            if ((bus.hcount_in != eh_q) || (bus.vcount_in != ev_q)) begin
                err_d = 1'b1;
            end
            if (eh_last) begin
                eh_d = '0;
                ev_d = ev_last ? '0 : ev_q + 10'd1;
            end else begin
                eh_d = eh_q + 11'd1;
            end
        end

        // In-flight count; a stray pixel with nothing in flight cannot underflow it
        if (accept && !(pix_hs && (outstanding_q != '0))) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!accept && pix_hs && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d       = ISSUE;
                    h_d           = '0;
                    v_d           = '0;
                    eh_d          = '0;
                    ev_d          = '0;
                    outstanding_d = '0;
                    err_d         = 1'b0;
                end
            end
            ISSUE: begin
                if (accept && h_last && v_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last pixel returned and its write is on the bus this cycle
                if (outstanding_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            h_q           <= '0;
            v_q           <= '0;
            eh_q          <= '0;
            ev_q          <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_wdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            eh_q          <= eh_d;
            ev_q          <= ev_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_wdata_q    <= fb_wdata_d;
        end
    end

    assign bus.busy               = (state_q != IDLE);
    assign bus.frame_done         = (state_q == DONE);
    assign bus.hcount_axis_tvalid = coord_valid;
    assign bus.vcount_axis_tvalid = coord_valid;
    assign bus.hcount_axis_tdata  = h_q;
    assign bus.vcount_axis_tdata  = v_q;
    assign bus.pixel_axis_tready  = pixel_ready;
    assign bus.fb_we              = fb_we_q;
    assign bus.fb_addr            = fb_addr_q;
    assign bus.fb_wdata           = fb_wdata_q;
    assign bus.err_order          = err_q;
    assign dbg_state              = state_q;
endmodule

// File: tb/tb_render_scheduler.sv
// Bench for render_scheduler with a 4x2 frame and three coordinates in flight.
module tb_render_scheduler;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int MAXO = 3;
  localparam int AW   = 20;
  localparam int N    = H * V;

  // ---------------- clock / reset ----------------
  logic       aclk = 1'b0;
  logic       areset;
  logic [1:0] dbg_state;

  always #5 aclk = ~aclk;

  render_scheduler_if #(.ADDR_W(AW)) bus();

  render_scheduler #(
    .H_ACTIVE(H), .V_ACTIVE(V), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  // ---------------- coordinate tready driver ----------------
  int rdy_mode = 0;  // 0: both ready, 1: random, 2: hcount stalled
  initial begin
    bus.hcount_axis_tready = 1'b1;
    bus.vcount_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #3;
      case (rdy_mode)
        1: begin
          bus.hcount_axis_tready = ($urandom_range(0, 3) != 0);
          bus.vcount_axis_tready = ($urandom_range(0, 3) != 0);
        end
        2: begin
          bus.hcount_axis_tready = 1'b0;
          bus.vcount_axis_tready = 1'b1;
        end
        default: begin
          bus.hcount_axis_tready = 1'b1;
          bus.vcount_axis_tready = 1'b1;
        end
      endcase
    end
  end

  // ---------------- loopback pixel pipeline ----------------
  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [23:0] d;
    int          due;
  } ret_t;

  ret_t lb_q[$];
  int   cyc           = 0;
  int   lb_lat        = 5;
  int   lb_budget     = -1;  // pixels still allowed back; -1 means unlimited
  bit   lb_rand       = 1'b0;
  bit   corrupt_first = 1'b0;

  initial begin
    ret_t r;
    bus.pixel_axis_tvalid = 1'b0;
    bus.pixel_axis_tdata  = '0;
    bus.hcount_in         = '0;
    bus.vcount_in         = '0;
    forever begin
      @(posedge aclk);
      cyc++;
      if (areset) begin
        lb_q.delete();
      end else begin
        if (bus.pixel_axis_tvalid && bus.pixel_axis_tready) begin
          void'(lb_q.pop_front());
          if (lb_budget > 0) lb_budget--;
        end
        if (bus.hcount_axis_tvalid && bus.hcount_axis_tready && bus.vcount_axis_tready) begin
          r.h   = bus.hcount_axis_tdata;
          r.v   = bus.vcount_axis_tdata;
          r.d   = 24'($urandom);
          r.due = cyc + (lb_rand ? int'($urandom_range(1, lb_lat)) : lb_lat);
          if (corrupt_first && r.h == 0 && r.v == 0) begin
            r.h           = 11'd2;
            r.d           = 24'hABCDEF;
            corrupt_first = 1'b0;
          end
          lb_q.push_back(r);
        end
      end
      #1;
      if (!areset && lb_q.size() > 0 && lb_q[0].due <= cyc && lb_budget != 0 &&
          (!lb_rand || $urandom_range(0, 3) != 0)) begin
        bus.pixel_axis_tvalid = 1'b1;
        bus.pixel_axis_tdata  = lb_q[0].d;
        bus.hcount_in         = lb_q[0].h;
        bus.vcount_in         = lb_q[0].v;
      end else begin
        bus.pixel_axis_tvalid = 1'b0;
      end
    end
  end

  // ---------------- transaction logs ----------------
  logic [10:0]   beat_h[$];
  logic [9:0]    beat_v[$];
  logic [AW-1:0] wr_addr[$];
  logic [23:0]   wr_data[$];
  int            done_cnt       = 0;
  int            writes_at_done = 0;

  always @(posedge aclk) begin
    if (!areset) begin
      if (bus.hcount_axis_tvalid && bus.hcount_axis_tready && bus.vcount_axis_tready) begin
        beat_h.push_back(bus.hcount_axis_tdata);
        beat_v.push_back(bus.vcount_axis_tdata);
      end
      if (bus.fb_we) begin
        wr_addr.push_back(bus.fb_addr);
        wr_data.push_back(bus.fb_wdata);
      end
      if (bus.frame_done) begin
        done_cnt++;
        writes_at_done = wr_addr.size();
      end
    end
  end

  // ---------------- behavioural reference model ----------------
  // Frame progress is tracked as "beats issued" and "pixels returned";
  // raster coordinates are derived from those counts by div/mod.
  int            m_phase;  // 0 idle, 1 issuing, 2 draining, 3 done
  int            m_issued;
  int            m_returned;
  bit            m_err;
  bit            m_fb_we;
  logic [AW-1:0] m_addr;
  logic [23:0]   m_data;
  bit            m_acc, m_pix;

  function automatic bit model_tvalid();
    return (m_phase == 1) && (m_issued < N) && ((m_issued - m_returned) < MAXO);
  endfunction

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_phase    = 0;
      m_issued   = 0;
      m_returned = 0;
      m_err      = 1'b0;
      m_fb_we    = 1'b0;
      m_addr     = '0;
      m_data     = '0;
    end else begin
      m_acc   = model_tvalid() && bus.hcount_axis_tready && bus.vcount_axis_tready;
      m_pix   = bus.pixel_axis_tvalid && (m_phase == 1 || m_phase == 2);
      m_fb_we = m_pix;
      if (m_pix) begin
        m_addr = AW'(int'(bus.vcount_in) * H + int'(bus.hcount_in));
        m_data = bus.pixel_axis_tdata;
        if (int'(bus.hcount_in) != m_returned % H || int'(bus.vcount_in) != m_returned / H)
          m_err = 1'b1;
      end
      case (m_phase)
        0: if (bus.start) begin
          m_phase    = 1;
          m_issued   = 0;
          m_returned = 0;
          m_err      = 1'b0;
        end
        1: if (m_acc && m_issued + 1 == N) m_phase = 2;
        2: if (m_returned == N) m_phase = 3;
        default: m_phase = 0;
      endcase
      if (m_acc) m_issued++;
      if (m_pix) m_returned++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge aclk) begin
    chk("busy", bus.busy, m_phase != 0);
    chk("frame_done", bus.frame_done, m_phase == 3);
    chk("hcount_tvalid", bus.hcount_axis_tvalid, model_tvalid());
    chk("vcount_tvalid", bus.vcount_axis_tvalid, model_tvalid());
    chk("pixel_tready", bus.pixel_axis_tready, m_phase == 1 || m_phase == 2);
    chk("fb_we", bus.fb_we, m_fb_we);
    chk("err_order", bus.err_order, m_err);
    if (model_tvalid()) begin
      chk("hcount_tdata", bus.hcount_axis_tdata, m_issued % H);
      chk("vcount_tdata", bus.vcount_axis_tdata, m_issued / H);
    end
    if (m_fb_we) begin
      chk("fb_addr", bus.fb_addr, m_addr);
      chk("fb_wdata", bus.fb_wdata, m_data);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.frame_done && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.frame_done) begin
      errors++;
      $display("FAIL %s_frame_done_timeout actual=0 expected=1 at %0t", name, $time);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_frame_writes(input string name, input int w0, input int d0);
    chk({name, "_write_count"}, wr_addr.size() - w0, N);
    for (int i = 0; i < N; i++)
      if (w0 + i < wr_addr.size()) chk({name, "_write_addr"}, wr_addr[w0 + i], i);
    chk({name, "_done_count"}, done_cnt - d0, 1);
    chk({name, "_writes_before_done"}, writes_at_done - w0, N);
  endtask

  // ---------------- main sequence ----------------
  int b0, w0, d0, n;

  initial begin
    bus.start = 1'b0;
    areset    = 1'b1;
    repeat (3) @(posedge aclk);
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_tvalid", {bus.hcount_axis_tvalid, bus.vcount_axis_tvalid}, 0);
    chk("rst_tdata", {bus.hcount_axis_tdata, bus.vcount_axis_tdata}, 0);
    chk("rst_pixel_tready", bus.pixel_axis_tready, 0);
    chk("rst_fb", {bus.fb_we, bus.fb_addr, bus.fb_wdata}, 0);
    chk("rst_err", bus.err_order, 0);
    chk("rst_state", dbg_state, 0);
    areset = 1'b0;
    tick();

    // Full frame with a fixed 5-cycle loopback
    b0 = beat_h.size(); w0 = wr_addr.size(); d0 = done_cnt;
    pulse_start();
    wait_done("t1");
    chk("t1_err", bus.err_order, 0);
    tick();
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_beat_count", beat_h.size() - b0, N);
    for (int i = 0; i < N; i++)
      if (b0 + i < beat_h.size()) begin
        chk("t1_beat_h", beat_h[b0 + i], i % H);
        chk("t1_beat_v", beat_v[b0 + i], i / H);
      end
    check_frame_writes("t1", w0, d0);

    // Nothing returns: issue stops at the in-flight cap, then one return frees a slot
    b0 = beat_h.size(); w0 = wr_addr.size(); d0 = done_cnt;
    lb_budget = 0;
    pulse_start();
    repeat (20) tick();
    chk("t2_capped_beats", beat_h.size() - b0, 3);
    chk("t2_capped_tvalid", bus.hcount_axis_tvalid, 0);
    lb_budget = 1;
    repeat (12) tick();
    chk("t2_beats_after_return", beat_h.size() - b0, 4);
    if (beat_h.size() > 0) begin
      chk("t2_fourth_h", beat_h[beat_h.size() - 1], 3);
      chk("t2_fourth_v", beat_v[beat_v.size() - 1], 0);
    end
    lb_budget = -1;
    wait_done("t2");
    tick();
    check_frame_writes("t2", w0, d0);

    // hcount tready held low for 3 cycles while (1,0) is offered
    b0 = beat_h.size(); w0 = wr_addr.size(); d0 = done_cnt;
    pulse_start();
    chk("t3_first_h", bus.hcount_axis_tdata, 0);
    tick();
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_tvalid", bus.hcount_axis_tvalid, 1);
      chk("t3_stall_hv", {bus.hcount_axis_tdata, bus.vcount_axis_tdata}, {11'd1, 10'd0});
      tick();
    end
    chk("t3_stall_hv_end", {bus.hcount_axis_tdata, bus.vcount_axis_tdata}, {11'd1, 10'd0});
    chk("t3_beats_during_stall", beat_h.size() - b0, 1);
    rdy_mode = 0;
    tick();
    chk("t3_beats_after_release", beat_h.size() - b0, 2);
    chk("t3_next_h", bus.hcount_axis_tdata, 2);
    wait_done("t3");
    tick();
    check_frame_writes("t3", w0, d0);

    // First returned pixel carries the wrong coordinate
    w0 = wr_addr.size();
    corrupt_first = 1'b1;
    pulse_start();
    wait_done("t4");
    chk("t4_err_at_done", bus.err_order, 1);
    tick();
    if (wr_addr.size() > w0) begin
      chk("t4_first_addr", wr_addr[w0], 2);
      chk("t4_first_data", wr_data[w0], 24'hABCDEF);
    end
    chk("t4_write_count", wr_addr.size() - w0, N);

    // Reset in the middle of a frame
    b0 = beat_h.size(); d0 = done_cnt;
    pulse_start();
    chk("t5_err_cleared", bus.err_order, 0);
    n = 0;
    while (beat_h.size() - b0 < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_reached_five_beats", beat_h.size() - b0, 5);
    #1 areset = 1'b1;
    #1;
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_tvalid", {bus.hcount_axis_tvalid, bus.vcount_axis_tvalid}, 0);
    chk("t5_rst_fb_we", bus.fb_we, 0);
    chk("t5_rst_frame_done", bus.frame_done, 0);
    tick();
    tick();
    areset = 1'b0;
    repeat (5) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    b0 = beat_h.size(); w0 = wr_addr.size(); d0 = done_cnt;
    pulse_start();
    wait_done("t5");
    tick();
    if (beat_h.size() > b0) chk("t5_restart_origin", {beat_h[b0], beat_v[b0]}, 0);
    check_frame_writes("t5", w0, d0);

    // start pulsed again while issuing is ignored
    b0 = beat_h.size(); w0 = wr_addr.size(); d0 = done_cnt;
    pulse_start();
    tick();
    tick();
    pulse_start();
    wait_done("t6");
    tick();
    chk("t6_beat_count", beat_h.size() - b0, N);
    check_frame_writes("t6", w0, d0);

    // Randomized readiness and loopback timing
    rdy_mode = 1;
    lb_rand  = 1'b1;
    for (int f = 0; f < 6; f++) begin
      w0 = wr_addr.size(); d0 = done_cnt;
      lb_lat = $urandom_range(1, 8);
      pulse_start();
      wait_done("rand");
      tick();
      check_frame_writes("rand", w0, d0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rdy_mode = 0;
    lb_rand  = 1'b0;

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end
endmodule
